// File: rtl/multi_key_debounce.sv
// N-channel active-low push-button conditioner: 2-flop sync, stability filter, press/release strobes.
// Optional auto-repeat on held keys when MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN is defined.
module multi_key_debounce #(
  parameter int N_KEYS        = 4,
  parameter int STABLE_CYCLES = 1000,
  parameter int HOLD_CYCLES   = 50000,
  parameter int REPEAT_CYCLES = 10000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [N_KEYS-1:0] i_in,
  output logic [N_KEYS-1:0] o_debounced,
  output logic [N_KEYS-1:0] o_neg,
  output logic [N_KEYS-1:0] o_pos
);

  localparam int              CW       = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_LAST = CW'(STABLE_CYCLES - 1);

  if (N_KEYS < 1 || STABLE_CYCLES < 2 || HOLD_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
    $error("multi_key_debounce: illegal parameter value");
  end

  logic [N_KEYS-1:0]         s1_q, s1_d;
  logic [N_KEYS-1:0]         s2_q, s2_d;
  logic [N_KEYS-1:0]         deb_q, deb_d;
  logic [N_KEYS-1:0]         neg_q, neg_d;
  logic [N_KEYS-1:0]         pos_q, pos_d;
  logic [N_KEYS-1:0][CW-1:0] cnt_q, cnt_d;

`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
  localparam int            HMAX      = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int            HW        = $clog2(HMAX + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic [N_KEYS-1:0][HW-1:0] hold_q, hold_d;
  logic [N_KEYS-1:0]         rep_q, rep_d;
`endif

  // Next-state logic: synchroniser shift, per-channel stability filter and strobe generation
  always_comb begin
    s1_d  = i_in;
    s2_d  = s1_q;
    deb_d = deb_q;
    neg_d = '0;
    pos_d = '0;
    cnt_d = cnt_q;
`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
    hold_d = hold_q;
    rep_d  = rep_q;
`endif
    for (int i = 0; i < N_KEYS; i++) begin
      if (s2_q[i] == deb_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        deb_d[i] = s2_q[i];
        cnt_d[i] = '0;
        neg_d[i] = ~s2_q[i];
        pos_d[i] = s2_q[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
      // An accepted edge takes priority so a repeat can never coincide with a release strobe.
      if ((deb_d[i] != deb_q[i]) || deb_q[i]) begin
        hold_d[i] = '0;
        rep_d[i]  = 1'b0;
      end else if (hold_q[i] == (rep_q[i] ? REP_LAST : HOLD_LAST)) begin
        neg_d[i]  = 1'b1;
        hold_d[i] = '0;
        rep_d[i]  = 1'b1;
      end else begin
        hold_d[i] = hold_q[i] + HW'(1);
      end
`endif
    end
  end

  // State registers; synchroniser and level reset to the released (high) state
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_q  <= '1;
      s2_q  <= '1;
      deb_q <= '1;
      neg_q <= '0;
      pos_q <= '0;
      cnt_q <= '0;
`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
      hold_q <= '0;
      rep_q  <= '0;
`endif
    end else begin
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      deb_q <= deb_d;
      neg_q <= neg_d;
      pos_q <= pos_d;
      cnt_q <= cnt_d;
`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
      hold_q <= hold_d;
      rep_q  <= rep_d;
`endif
    end
  end

  assign o_debounced = deb_q;
  assign o_neg       = neg_q;
  assign o_pos       = pos_q;

endmodule

// File: tb/tb_multi_key_debounce.sv
// Directed bench for multi_key_debounce: expected strobe events are queued at drive time
// and compared every cycle against the outputs.
module tb_multi_key_debounce;

  localparam int N   = 4;
  localparam int S   = 8;
  localparam int H   = 20;
  localparam int R   = 5;
  // Input driven just after cycle c lands on edge c+1; filter output follows at edge c+1+1+S.
  localparam int LAT = S + 2;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [N-1:0] in;
  logic [N-1:0] deb, neg, pos;

  int cyc    = 0;
  int errors = 0;
  int checks = 0;

  typedef struct {
    int         cyc;
    logic [3:0] neg;
    logic [3:0] pos;
    logic [3:0] deb;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       cur;
  logic [3:0] exp_deb = 4'hF;
  logic [3:0] exp_neg;
  logic [3:0] exp_pos;
  int         base;

  multi_key_debounce #(
    .N_KEYS       (N),
    .STABLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .REPEAT_CYCLES(R)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_in       (in),
    .o_debounced(deb),
    .o_neg      (neg),
    .o_pos      (pos)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, expv);
    end
  endtask

  task automatic push(input int c, input logic [3:0] n, input logic [3:0] p, input logic [3:0] d);
    sb_q.push_back('{cyc: c, neg: n, pos: p, deb: d});
  endtask

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  // Drive a new key pattern and queue the strobe expected once it has been filtered.
  task automatic drive(input logic [3:0] v, input logic [3:0] n, input logic [3:0] p);
    in = v;
    push(cyc + LAT, n, p, v);
  endtask

  // Monitor: reset values while in reset, otherwise queued events or quiet strobes.
  initial forever begin
    @(negedge clk);
    if (rst_n !== 1'b1) begin
      exp_deb = 4'hF;
      check("rst_deb", deb, 4'hF);
      check("rst_neg", neg, 4'h0);
      check("rst_pos", pos, 4'h0);
    end else begin
      exp_neg = 4'h0;
      exp_pos = 4'h0;
      if (sb_q.size() > 0 && sb_q[0].cyc == cyc) begin
        cur     = sb_q.pop_front();
        exp_neg = cur.neg;
        exp_pos = cur.pos;
        exp_deb = cur.deb;
      end
      check("neg", neg, exp_neg);
      check("pos", pos, exp_pos);
      check("deb", deb, exp_deb);
    end
  end

  initial begin
    // 1: keys held low through reset are reported only after release plus full filtering
    rst_n = 1'b0;
    in    = 4'h0;
    wait_n(4);
    rst_n = 1'b1;
    push(cyc + LAT, 4'hF, 4'h0, 4'h0);
    wait_n(14);
    drive(4'hF, 4'h0, 4'hF);
    wait_n(14);

    // 2: clean press and release on channel 1
    drive(4'b1101, 4'b0010, 4'h0);
    wait_n(14);
    drive(4'hF, 4'h0, 4'b0010);
    wait_n(14);

    // 3: channel 0 bounces every 3 cycles, never stable long enough
    for (int k = 0; k < 10; k++) begin
      in[0] = (k % 2 == 1) ? 1'b1 : 1'b0;
      wait_n(3);
    end
    in[0] = 1'b1;
    wait_n(15);

    // 4: channels 0 and 3 change together
    drive(4'b0110, 4'b1001, 4'h0);
    wait_n(14);
    drive(4'hF, 4'h0, 4'b1001);
    wait_n(14);

    // 5: reset while channel 0 is mid-count; pending press must be discarded
    in   = 4'b1110;
    wait_n(7);
    rst_n = 1'b0;
    sb_q.delete();
    wait_n(3);
    rst_n = 1'b1;
    push(cyc + LAT, 4'b0001, 4'h0, 4'b1110);
    wait_n(14);
    drive(4'hF, 4'h0, 4'b0001);
    wait_n(14);

    // 6: channel 2 held long; repeats only with auto-repeat built in
    base = cyc + LAT;
    drive(4'b1011, 4'b0100, 4'h0);
`ifdef MULTI_KEY_DEBOUNCE_AUTO_REPEAT_EN
    push(base + H, 4'b0100, 4'h0, 4'b1011);
    for (int t = base + H + R; t <= base + 60; t += R) begin
      push(t, 4'b0100, 4'h0, 4'b1011);
    end
`endif
    wait_n(62);
    drive(4'hF, 4'h0, 4'b0100);
    wait_n(25);

    checks++;
    assert (sb_q.size() == 0) else begin
      errors++;
      $error("FAIL sb_drain observed=%0d expected=0 pending events", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
